// File: rtl/assert_window_checker_if.sv
// assert_window_checker_if: control, status and readback bundle
// master drives en/a/b/disables/clr/rd_ch; slave returns fail/pending/counts
interface assert_window_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int RD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                en;
  logic [NUM_CH-1:0]   a;
  logic [NUM_CH-1:0]   b;
  logic                dflt_dis;
  logic [NUM_CH-1:0]   ch_dis;
  logic [2*NUM_CH-1:0] dis_sel;
  logic                clr;
  logic [RD_W-1:0]     rd_ch;
  logic [NUM_CH-1:0]   fail_pulse;
  logic [NUM_CH-1:0]   fail_sticky;
  logic                irq;
  logic [NUM_CH-1:0]   pending;
  logic [CNT_W-1:0]    rd_pass_cnt;
  logic [CNT_W-1:0]    rd_fail_cnt;

  modport master (
    output en, a, b, dflt_dis, ch_dis,
    output dis_sel, clr, rd_ch,
    input  fail_pulse, fail_sticky, irq,
    input  pending, rd_pass_cnt, rd_fail_cnt
  );

  modport slave (
    input  en, a, b, dflt_dis, ch_dis,
    input  dis_sel, clr, rd_ch,
    output fail_pulse, fail_sticky, irq,
    output pending, rd_pass_cnt, rd_fail_cnt
  );
endinterface

// File: rtl/assert_window_checker.sv
// assert_window_checker: per-channel "a then b within [MIN,MAX]" monitor
// ports: clk, rst_n (async low), bus (slave) with fail/sticky/irq/counters
module assert_window_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 1,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst_n,
  assert_window_checker_if.slave bus
);
  localparam int RD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RD_N = 1 << RD_W;

  typedef logic [MAX_DLY:1] pend_t;
  typedef logic [CNT_W-1:0] cnt_t;

  pend_t pend_q [NUM_CH];
  pend_t pend_d [NUM_CH];
  cnt_t  pass_q [NUM_CH];
  cnt_t  pass_d [NUM_CH];
  cnt_t  fail_q [NUM_CH];
  cnt_t  fail_d [NUM_CH];

  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [NUM_CH-1:0] dis, pass_ev, fail_ev;

  function automatic cnt_t nxt_cnt(
    input cnt_t c,
    input logic ev,
    input logic clr
  );
    if (clr)
      return cnt_t'(ev);
    else if (ev && !(&c))
      return c + cnt_t'(1);
    else
      return c;
  endfunction

  always_comb begin
    dis = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (bus.dis_sel[2*i +: 2])
        2'b00:   dis[i] = ~bus.en | bus.dflt_dis;
        2'b01:   dis[i] = ~bus.en | bus.ch_dis[i];
        default: dis[i] = ~bus.en;
      endcase
    end
  end

  // pend[k]: attempt aged k still open; b only
  // retires ages inside the window
  always_comb begin
    pass_ev = '0;
    fail_ev = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i] = '0;
      if (!dis[i]) begin
        for (int k = MIN_DLY; k <= MAX_DLY; k++)
          pass_ev[i] = pass_ev[i]
                     | (pend_q[i][k] & bus.b[i]);
        fail_ev[i] = pend_q[i][MAX_DLY] & ~bus.b[i];
        pend_d[i][1] = bus.a[i];
        for (int k = 1; k < MAX_DLY; k++)
          pend_d[i][k+1] = pend_q[i][k]
                         & ~(bus.b[i] & (k >= MIN_DLY));
      end
    end
  end

  always_comb begin
    pulse_d  = fail_ev;
    sticky_d = fail_ev | (sticky_q & ~{NUM_CH{bus.clr}});
    for (int i = 0; i < NUM_CH; i++) begin
      pass_d[i] = nxt_cnt(pass_q[i], pass_ev[i], bus.clr);
      fail_d[i] = nxt_cnt(fail_q[i], fail_ev[i], bus.clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q  <= '0;
      sticky_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= '0;
        pass_q[i] <= '0;
        fail_q[i] <= '0;
      end
    end else begin
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= pend_d[i];
        pass_q[i] <= pass_d[i];
        fail_q[i] <= fail_d[i];
      end
    end
  end

  // readback table padded to the full rd_ch
  // range so unused selects return zero
  cnt_t pass_rd [RD_N];
  cnt_t fail_rd [RD_N];

  always_comb begin
    for (int j = 0; j < RD_N; j++) begin
      pass_rd[j] = '0;
      fail_rd[j] = '0;
    end
    for (int j = 0; j < NUM_CH; j++) begin
      pass_rd[j] = pass_q[j];
      fail_rd[j] = fail_q[j];
    end
  end

  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < NUM_CH; i++)
      bus.pending[i] = |pend_q[i];
  end

  assign bus.fail_pulse  = pulse_q;
  assign bus.fail_sticky = sticky_q;
  assign bus.irq         = |sticky_q;
  assign bus.rd_pass_cnt = pass_rd[bus.rd_ch];
  assign bus.rd_fail_cnt = fail_rd[bus.rd_ch];

endmodule

// File: doc/assert_window_checker.md
Name: assert_window_checker

Overview:
- Synthesizable, parametrised successor to our simulation-only "a |=> b" implication assertions.
- NUM_CH independent channels. Each checks that antecedent a[i] is followed by consequent b[i] within a cycle window [MIN_DLY, MAX_DLY].
- Per-channel disable selection mirrors SVA disable semantics: default disable, explicit disable, or none (1'b0).
- Sits beside datapath blocks as an on-chip protocol monitor. Provides fail pulses, sticky flags, saturating counters and an interrupt.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- MIN_DLY, 1: earliest cycle after a at which b satisfies an attempt (>=1).
- MAX_DLY, 1: latest such cycle (>=MIN_DLY). Defaults give exact |=> semantics.
- CNT_W, 16: width of per-channel pass/fail counters.

Ports:
- clk  in  1  sampling clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global checker enable; 0 behaves as a disable on all channels.
- a  in  NUM_CH  per-channel antecedent.
- b  in  NUM_CH  per-channel consequent.
- dflt_dis  in  1  default disable condition, shared by all channels.
- ch_dis  in  NUM_CH  per-channel explicit disable condition.
- dis_sel  in  2*NUM_CH  per-channel selection: 00 = dflt_dis, 01 = ch_dis[i], 10/11 = never disabled.
- clr  in  1  synchronous clear of sticky flags and counters.
- rd_ch  in  max(1,$clog2(NUM_CH))  channel select for counter readback.
- fail_pulse  out  NUM_CH  registered one-cycle fail indication.
- fail_sticky  out  NUM_CH  sticky fail flag.
- irq  out  1  OR of fail_sticky.
- pending  out  NUM_CH  channel has at least one outstanding attempt.
- rd_pass_cnt  out  CNT_W  pass counter of channel rd_ch (combinational mux of registers).
- rd_fail_cnt  out  CNT_W  fail counter of channel rd_ch.

Behaviour:
- Reset: all outputs, pending vectors and counters are 0 while rst_n=0. Release takes effect at the next edge.
- Effective disable: dis[i] = ~en | sel(dis_sel[i]); the selected condition is sampled at clk.
- State per channel: pend[1..MAX_DLY]. pend[k] means an attempt started k cycles ago and is still unsatisfied.
- Each edge with dis[i]=0:
  - ok = b[i]. pass_ev = OR over k in [MIN_DLY, MAX_DLY] of pend[k] & ok. fail_ev = pend[MAX_DLY] & ~ok.
  - Next state: pend[1] <= a[i]; pend[k+1] <= pend[k] & ~(ok & k>=MIN_DLY).
- Overlapping attempts are independent. One b cycle satisfies every attempt whose age is within the window.
- b at age < MIN_DLY does not satisfy an attempt and does not fail it.
- a and b in the same cycle: b does not satisfy the new attempt.
- Each edge with dis[i]=1:
  - pend cleared; no pass or fail event; a[i] ignored.
  - Aborted attempts are neither passes nor fails.
- fail_pulse[i] <= fail_ev, so it is high in the cycle after the failing sample.
- fail_sticky[i] is set by fail_ev and cleared by clr. If set and clear occur together, set wins.
- Counters:
  - pass_cnt increments by 1 per edge with pass_ev, even if several attempts pass in that cycle.
  - fail_cnt increments by 1 per fail_ev.
  - Both saturate at 2^CNT_W-1.
  - clr zeroes them. If clr and an event coincide, the counter becomes 1.
- pending[i] = |pend (registered state).
- irq = |fail_sticky.
- rd_ch >= NUM_CH reads 0.
- Reset asserted mid-attempt: all state cleared immediately, no fail reported.

Test Plan:
- Defaults, ch0 dis_sel=10. a=1 @T0, b=1 @T1 -> pass_cnt=1, no fail_pulse. a=1 @T2, b=0 @T3 -> fail_pulse[0]=1 @T4, fail_sticky[0]=1, irq=1, fail_cnt=1.
- Defaults, ch1 dis_sel=00. dflt_dis=1 @T1 after a @T0, b=0 @T1 -> no fail, pending[1]=0 @T2, counters unchanged. Switch to dis_sel=10 and repeat -> fail_cnt=1.
- ch2 dis_sel=01, ch_dis[2]=1, dflt_dis=0 -> failing stimulus produces no fail. With dflt_dis=1 and ch_dis[2]=0 -> fail detected (the explicit condition overrides the default).
- MIN_DLY=2, MAX_DLY=4. a @T0, b @T1 only -> fail_pulse @T5. a @T0 and a @T1, single b @T3 -> both pass, pass_cnt=1, no fail.
- CNT_W=3, 9 consecutive failures -> fail_cnt saturates at 7. clr together with a fail -> fail_cnt=1, fail_sticky=1.
- rst_n=0 while pend has bits set, during en=1 -> outputs 0 asynchronously. After release, no spurious fail_pulse; rd_ch=NUM_CH reads 0.
